// File: rtl/fc_prim_pkg.sv
// Fibre Channel transmit primitives: 36-bit word constants, state/code enums
// and the byte+K packing helper shared by the tx scheduler.
package fc_prim_pkg;

  typedef enum logic [1:0] {
    PS_NOS = 2'd0,
    PS_OLS = 2'd1,
    PS_LR  = 2'd2,
    PS_LRR = 2'd3
  } ps_code_e;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FRAME = 2'd1,
    ST_PSEQ  = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  // Byte i lands in [9i+7:9i] with its K flag at bit 9i+8; byte 0 goes out first.
  function automatic logic [35:0] pack_word(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3,
                                            input logic [3:0] k);
    return {k[3], b3, k[2], b2, k[1], b1, k[0], b0};
  endfunction

  localparam logic [35:0] IDLE_W = pack_word(8'hBC, 8'h95, 8'hB5, 8'hB5, 4'b0001);
  localparam logic [35:0] NOS_W  = pack_word(8'hBC, 8'h55, 8'hBF, 8'h45, 4'b0001);
  localparam logic [35:0] OLS_W  = pack_word(8'hBC, 8'h35, 8'h8A, 8'h55, 4'b0001);
  localparam logic [35:0] LR_W   = pack_word(8'hBC, 8'h49, 8'hBF, 8'h49, 4'b0001);
  localparam logic [35:0] LRR_W  = pack_word(8'hBC, 8'h35, 8'hBF, 8'h49, 4'b0001);

  function automatic logic [35:0] ps_word(input ps_code_e code);
    case (code)
      PS_NOS:  return NOS_W;
      PS_OLS:  return OLS_W;
      PS_LR:   return LR_W;
      default: return LRR_W;
    endcase
  endfunction

endpackage

// File: rtl/fc_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module fc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (clr_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fc_tx_scheduler.sv
// Per-cycle selector of frame word, primitive sequence or IDLE fill in front
// of the 36-bit transceiver input, with inter-frame gap enforcement.
module fc_tx_scheduler
  import fc_prim_pkg::*;
#(
  parameter int MIN_FILL = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phy_ready,
  output logic [35:0]      phy_data,
  input  logic [35:0]      frm_data,
  input  logic             frm_valid,
  input  logic             frm_sop,
  input  logic             frm_eop,
  output logic             frm_ready,
  input  logic             ps_en,
  input  logic [1:0]       ps_code,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] frames_sent,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int FILL_W = $clog2(MIN_FILL + 1);

  sched_state_e      state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [35:0]       phy_data_q, phy_data_d;
  logic              fill_ok;
  logic              frames_inc, underrun_inc, drop_inc;

  assign fill_ok = (fill_cnt_q == FILL_W'(MIN_FILL));

  // NOTE: every output of this block gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    phy_data_d   = IDLE_W;
    frm_ready    = 1'b0;
    frames_inc   = 1'b0;
    underrun_inc = 1'b0;
    drop_inc     = 1'b0;

    if (!phy_ready) begin
      // Link not ready: hold IDLE, restart the gap, abandon any frame in flight.
      fill_cnt_d = '0;
      case (state_q)
        ST_FRAME: state_d = ST_FLUSH;
        ST_FLUSH: begin
          frm_ready = 1'b1;
          if (frm_valid) begin
            drop_inc = 1'b1;
            if (frm_eop) state_d = ST_FILL;
          end
        end
        default:  state_d = ST_FILL;
      endcase
    end else begin
      case (state_q)
        ST_FILL: begin
          if (ps_en) begin
            state_d = ST_PSEQ;
          end else if (frm_valid && frm_sop && fill_ok) begin
            frm_ready  = 1'b1;
            phy_data_d = frm_data;
            if (frm_eop) begin
              frames_inc = 1'b1;
              fill_cnt_d = '0;
            end else begin
              state_d = ST_FRAME;
            end
          end else begin
            if (!fill_ok) fill_cnt_d = fill_cnt_q + FILL_W'(1);
            if (frm_valid && !frm_sop) begin
              frm_ready = 1'b1;
              drop_inc  = 1'b1;
            end
          end
        end
        ST_FRAME: begin
          frm_ready = 1'b1;
          if (frm_valid) begin
            phy_data_d = frm_data;
            if (frm_eop) begin
              state_d    = ST_FILL;
              fill_cnt_d = '0;
              frames_inc = 1'b1;
            end
          end else begin
            underrun_inc = 1'b1;
          end
        end
        ST_PSEQ: begin
          if (ps_en) begin
            phy_data_d = ps_word(ps_code_e'(ps_code));
          end else begin
            state_d    = ST_FILL;
            fill_cnt_d = '0;
          end
        end
        default: begin
          frm_ready = 1'b1;
          if (frm_valid) begin
            drop_inc = 1'b1;
            if (frm_eop) begin
              state_d    = ST_FILL;
              fill_cnt_d = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      phy_data_q <= IDLE_W;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      phy_data_q <= phy_data_d;
    end
  end

  assign phy_data = phy_data_q;
  assign state_o  = state_q;

  fc_sat_counter #(.WIDTH(CNT_W)) u_frames_cnt (
    .clk    (clk),
    .clr_i  (reset),
    .inc_i  (frames_inc),
    .count_o(frames_sent)
  );

  fc_sat_counter #(.WIDTH(CNT_W)) u_underrun_cnt (
    .clk    (clk),
    .clr_i  (reset),
    .inc_i  (underrun_inc),
    .count_o(underrun_cnt)
  );

  fc_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk    (clk),
    .clr_i  (reset),
    .inc_i  (drop_inc),
    .count_o(drop_cnt)
  );

endmodule

// File: doc/fc_tx_scheduler.md
Name: fc_tx_scheduler

Overview:
- Transmit-side word scheduler in the tx_clk domain, sitting directly in front of the FC 8G transceiver's 36-bit tx_data input.
- Every cycle it picks exactly one word from three sources: upstream frame words, a selected continuous primitive sequence (NOS/OLS/LR/LRR), or IDLE fill.
- Enforces the minimum fill-word gap between frames and never interleaves sources inside a frame.
- Word format: byte i occupies bits [9i+7:9i] with K flag at bit 9i+8; byte 0 is transmitted first.

Parameters:
- MIN_FILL, 6: minimum IDLE words between frame end (or reset, or link-down, or primitive sequence end) and the next SOP.
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk in 1: tx_clk from transceiver.
- reset in 1: synchronous, active-high.
- phy_ready in 1: transceiver tx_ready.
- phy_data out 36: word to transceiver, registered.
- frm_data in 36: frame word (same byte/K layout).
- frm_valid in 1: frame word valid.
- frm_sop in 1: first word of frame.
- frm_eop in 1: last word of frame.
- frm_ready out 1: word accepted when frm_valid && frm_ready.
- ps_en in 1: request continuous primitive sequence.
- ps_code in 2: 0=NOS, 1=OLS, 2=LR, 3=LRR.
- state_o out 2: 0=FILL, 1=FRAME, 2=PSEQ, 3=FLUSH.
- frames_sent out CNT_W: saturating count of EOPs transmitted.
- underrun_cnt out CNT_W: saturating count of FRAME cycles with frm_valid low.
- drop_cnt out CNT_W: saturating count of words discarded (non-SOP words in FILL, plus all FLUSH words).

Behaviour:
- Constants (byte0..byte3, K only on byte0):
  - IDLE = K28.5 D21.4 D21.5 D21.5 (BC 95 B5 B5)
  - NOS = BC 55 BF 45
  - OLS = BC 35 8A 55
  - LR = BC 49 BF 49
  - LRR = BC 35 BF 49
- Reset: state FILL, phy_data=IDLE, fill_cnt=0, all counters 0, frm_ready=0.
- Output timing: phy_data is registered. A word accepted or selected in cycle N appears on phy_data in N+1. frm_ready is combinational from state, fill_cnt, frm_sop, frm_valid and phy_ready.
- fill_cnt: counts IDLE words emitted in FILL and saturates at MIN_FILL. fill_ok = (fill_cnt == MIN_FILL).
- phy_ready=0 overrides everything:
  - phy_data <= IDLE and fill_cnt <= 0.
  - From FRAME, go to FLUSH. From FILL or PSEQ, go to FILL.
  - In FLUSH, discarding continues.
- FILL:
  - Emit IDLE.
  - If ps_en, go to PSEQ next cycle; frames are not accepted that cycle. ps_en has priority over SOP.
  - Else if frm_valid && frm_sop && fill_ok: frm_ready=1, word forwarded, go to FRAME. If frm_eop is also set (single-word frame), stay in FILL, set fill_cnt=0 and increment frames_sent.
  - Else if frm_valid && !frm_sop: frm_ready=1, word discarded, drop_cnt++.
- FRAME:
  - frm_ready=1.
  - Valid word: forward it. On eop, go to FILL, fill_cnt=0, frames_sent++.
  - !frm_valid: emit IDLE, underrun_cnt++, stay in FRAME.
  - ps_en is ignored until the frame ends.
  - A second SOP without a preceding EOP is forwarded as data (no checking).
- PSEQ:
  - Emit the word for the current ps_code every cycle; a ps_code change takes effect on the next word.
  - frm_ready=0.
  - When ps_en drops, go to FILL with fill_cnt=0.
- FLUSH:
  - frm_ready=1, emit IDLE, drop_cnt++ per accepted word.
  - On accepted eop, go to FILL with fill_cnt=0. This holds even if phy_ready has returned high.
- Counters saturate at all-ones and never wrap.

Decomposition:
- fc_prim_pkg: 36-bit IDLE/NOS/OLS/LR/LRR constants, ps_code enum, state enum, and a function packing four 8-bit bytes plus a K mask into 36 bits.
- fc_sat_counter (WIDTH, inc, clr): single sub-module, instantiated three times.

Test Plan:
- Reset release, frm_valid=0, phy_ready=1 -> phy_data = IDLE every cycle, state_o=0, frm_ready=0.
- 3-word frame (W0 sop, W1, W2 eop) presented at cycle 0 after reset:
  - frm_ready first rises at cycle 6 (MIN_FILL=6); W0..W2 appear at cycles 7..9.
  - A back-to-back second frame's SOP appears no earlier than cycle 16.
  - frames_sent=2.
- frm_valid gap of 2 cycles mid-frame -> two IDLE words inside the frame, underrun_cnt=2, word order otherwise preserved.
- ps_en=1, ps_code=1 asserted mid-frame:
  - Frame completes, then OLS (BC 35 8A 55) repeats.
  - Switching ps_code to 2 yields LR on the next word.
  - Deasserting ps_en gives 6 IDLE before the next SOP is accepted.
- phy_ready dropped during word 2 of a 5-word frame:
  - state_o=3 and IDLE is output.
  - Remaining words are discarded; drop_cnt counts them, including the EOP.
  - Returns to FILL; the next frame waits MIN_FILL.
- Non-SOP words while in FILL -> discarded, drop_cnt increments by the number of words; force counter to all-ones and verify saturation.
